// File: rtl/axi4_burst_read_master.sv
// AXI4 read master: turns one (address, beat count) command into INCR bursts split at
// 4 KB and MAX_BURST boundaries, and streams R beats straight through to a consumer.
module axi4_burst_read_master #(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned CMD_LEN_W = 16,
    parameter int unsigned MAX_BURST = 256
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [ADDR_W-1:0]    cmd_addr,
    input  logic [CMD_LEN_W-1:0] cmd_beats,
    output logic                 arvalid,
    input  logic                 arready,
    output logic [ADDR_W-1:0]    araddr,
    output logic [7:0]           arlen,
    output logic [2:0]           arsize,
    output logic [1:0]           arburst,
    input  logic                 rvalid,
    output logic                 rready,
    input  logic [DATA_W-1:0]    rdata,
    input  logic [1:0]           rresp,
    input  logic                 rlast,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATA_W-1:0]    out_data,
    output logic                 out_last,
    output logic                 done,
    output logic                 err_resp,
    output logic                 err_last,
    output logic                 busy
);

    localparam int unsigned SZ    = $clog2(DATA_W / 8);
    localparam int unsigned CNT_W = CMD_LEN_W + 1;
    localparam int unsigned MW    = (CNT_W > 13) ? CNT_W : 13;
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~(ADDR_W'((64'd1 << SZ) - 64'd1));

    typedef enum logic [2:0] {
        S_IDLE,
        S_CALC,
        S_ADDR,
        S_DATA,
        S_DONE
    } state_t;

    state_t               r_state;
    logic [ADDR_W-1:0]    r_addr;
    logic [CNT_W-1:0]     r_rem;
    logic [8:0]           r_n;
    logic [7:0]           r_cnt;
    logic                 r_cmd_ready;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_err_resp;
    logic                 r_err_last;
    logic                 r_arvalid;
    logic [ADDR_W-1:0]    r_araddr;
    logic [7:0]           r_arlen;

    logic [MW-1:0]        w_btb;
    logic [MW-1:0]        w_rem;
    logic [MW-1:0]        w_lim;
    logic [MW-1:0]        w_n1;
    logic [MW-1:0]        w_n;
    logic                 w_in_data;
    logic                 w_beat;
    logic                 w_burst_end;
    logic                 w_final_burst;

    // Burst size: smallest of remaining beats, beats to the next 4 KB page, and MAX_BURST
    assign w_btb = MW'((13'd4096 - {1'b0, r_addr[11:0]}) >> SZ);
    assign w_rem = MW'(r_rem);
    assign w_lim = MW'(MAX_BURST);
    assign w_n1  = (w_rem < w_btb) ? w_rem : w_btb;
    assign w_n   = (w_n1 < w_lim) ? w_n1 : w_lim;

    // R channel is a zero-latency pass-through while a burst is in flight
    assign w_in_data     = (r_state == S_DATA);
    assign w_beat        = rvalid && rready;
    assign w_burst_end   = (r_cnt == 8'd0);
    assign w_final_burst = (r_rem == CNT_W'(r_n));

    assign rready    = w_in_data && out_ready;
    assign out_valid = w_in_data && rvalid;
    assign out_data  = rdata;
    assign out_last  = out_valid && w_burst_end && w_final_burst;

    assign cmd_ready = r_cmd_ready;
    assign arvalid   = r_arvalid;
    assign araddr    = r_araddr;
    assign arlen     = r_arlen;
    assign arsize    = 3'(SZ);
    assign arburst   = 2'b01;
    assign done      = r_done;
    assign err_resp  = r_err_resp;
    assign err_last  = r_err_last;
    assign busy      = r_busy;

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_state     <= S_IDLE;
            r_addr      <= '0;
            r_rem       <= '0;
            r_n         <= '0;
            r_cnt       <= '0;
            r_cmd_ready <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err_resp  <= 1'b0;
            r_err_last  <= 1'b0;
            r_arvalid   <= 1'b0;
            r_araddr    <= '0;
            r_arlen     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_cmd_ready <= 1'b1;
                    if (cmd_valid && r_cmd_ready) begin
                        r_addr      <= cmd_addr & ALIGN_MASK;
                        r_rem       <= CNT_W'(cmd_beats) + CNT_W'(1);
                        r_err_resp  <= 1'b0;
                        r_err_last  <= 1'b0;
                        r_busy      <= 1'b1;
                        r_cmd_ready <= 1'b0;
                        r_state     <= S_CALC;
                    end
                end
                S_CALC: begin
                    r_araddr  <= r_addr;
                    r_arlen   <= 8'(w_n - MW'(1));
                    r_cnt     <= 8'(w_n - MW'(1));
                    r_n       <= 9'(w_n);
                    r_arvalid <= 1'b1;
                    r_state   <= S_ADDR;
                end
                S_ADDR: begin
                    if (arready) begin
                        r_arvalid <= 1'b0;
                        r_state   <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (w_beat) begin
                        if (rresp != 2'b00) begin
                            r_err_resp <= 1'b1;
                        end
                        // The beat counter, not rlast, decides where a burst ends
                        if (rlast != w_burst_end) begin
                            r_err_last <= 1'b1;
                        end
                        r_cnt <= r_cnt - 8'd1;
                        if (w_burst_end) begin
                            r_rem  <= r_rem - CNT_W'(r_n);
                            r_addr <= r_addr + (ADDR_W'(r_n) << SZ);
                            if (w_final_burst) begin
                                r_done  <= 1'b1;
                                r_state <= S_DONE;
                            end else begin
                                r_state <= S_CALC;
                            end
                        end
                    end
                end
                S_DONE: begin
                    r_done      <= 1'b0;
                    r_busy      <= 1'b0;
                    r_cmd_ready <= 1'b1;
                    r_state     <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
